sap_control_unit: RTL and testbench
===================================

// Module: sap_control_unit
// PURPOSE
//  Microcoded control sequencer for the 16-bit SAP datapath: fetches and decodes instructions and drives alu_op.
//  Latches the ALU zero/overflow flags and uses them for conditional jumps.
//  Sits between the instruction register, the ALU and the bus-attached PC/MAR/RAM/A/B registers.
//  Emits one control word per clock.
// PARAMETERS
//  OPC_W   4   opcode width, ir[15:12]
//  ALUOP_W 4   alu_op width; codes are the shared `*_OP defines
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous reset, active low
//  run         in   1   1 = execute; 0 = stop at the next instruction boundary
//  ir          in   16  instruction register contents: [15:12] opcode, [11:0] operand
//  alu_flag    in   2   live ALU flags: [0] zero, [1] overflow
//  pc_out_en   out  1   PC drives bus
//  pc_inc      out  1   PC += 1 at the clock edge
//  pc_load     out  1   PC <= bus
//  mar_load    out  1   MAR <= bus
//  ram_rd      out  1   RAM drives bus
//  ram_wr      out  1   RAM[MAR] <= bus
//  ir_load     out  1   IR <= bus
//  ir_out_en   out  1   IR operand {4'b0, ir[11:0]} drives bus
//  a_load      out  1   A <= bus
//  a_out_en    out  1   A drives bus
//  b_load      out  1   B <= bus
//  alu_out_en  out  1   ALU result drives bus
//  alu_op      out  4   ALU operation code
//  flags_q     out  2   latched flags: [0] Z, [1] V
//  halted      out  1   1 while in HALT
// BEHAVIOUR
//  States: IDLE, F0, F1, DEC, EX1, EX2, HALT. Controls are a combinational decode of state, opcode and flags_q.
//  Reset: state=IDLE, flags_q=0, every control output 0, alu_op=0. Reset mid-instruction aborts at once.
//  IDLE: all controls 0. run=1 -> F0.
//  F0: pc_out_en, mar_load -> F1.
//  F1: ram_rd, ir_load, pc_inc -> DEC.
//  Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JZ, 8 JO, 9 INC, A DEC, B AND, C OR, D XOR, E NOT, F HLT.
//  DEC actions by opcode:
//   NOP: no controls -> boundary.
//   LDA/ADD/SUB/AND/OR/XOR/STA: ir_out_en, mar_load -> EX1.
//   LDI: ir_out_en, a_load -> boundary.
//   JMP: ir_out_en, pc_load -> boundary.
//   JZ/JO: if flags_q[0] (JZ) or flags_q[1] (JO) is 1: ir_out_en, pc_load; otherwise no controls -> boundary.
//   INC/DEC/NOT: alu_op set, alu_out_en, a_load, flag_load -> boundary.
//   HLT: -> HALT.
//  EX1 actions:
//   LDA: ram_rd, a_load -> boundary.
//   STA: a_out_en, ram_wr -> boundary.
//   ALU-class: ram_rd, b_load -> EX2.
//  EX2: alu_op set, alu_out_en, a_load, flag_load -> boundary.
//  Boundary: next state F0 if run=1, IDLE if run=0. Dropping run mid-instruction completes that instruction.
//  flag_load is internal: flags_q <= alu_flag at the edge ending that cycle. No other instruction alters flags_q.
//  Conditional jumps test flags_q, never live alu_flag.
//  alu_op: ADD->`ADD_OP, SUB->`SUB_OP, INC->`INC_OP, DEC->`DEC_OP, AND->`AND_OP, OR->`OR_OP, XOR->`XOR_OP, NOT->`NOT_OP.
//  alu_op is held for the instruction's DEC..EX2 cycles and is 0 in all other cycles.
//  Cycle counts: NOP/LDI/JMP/JZ/JO/INC/DEC/NOT = 3; LDA/STA = 4; ADD/SUB/AND/OR/XOR = 5.
//  HALT: halted=1, all other controls 0. Leaves only via rst_n; run is ignored.
//  Bus invariant: at most one of pc_out_en/ram_rd/ir_out_en/a_out_en/alu_out_en is 1 in any cycle.
//  ram_rd and ram_wr are never 1 together.
// TESTING
//  Reset then run=1, ir=16'h0000 -> F0,F1,DEC repeat every 3 cycles; pc_inc pulses once per 3 cycles.
//  ir=16'h2034 (ADD 0x034), alu_flag=2'b01 in EX2 -> 5-cycle sequence; alu_op=`ADD_OP in DEC..EX2; flags_q=2'b01 after EX2.
//  flags_q=2'b01 then ir=16'h7100 -> pc_load and ir_out_en in DEC. Repeat with flags_q=2'b00 -> no pc_load.
//  ir=16'h4010 (STA) -> EX1 asserts a_out_en and ram_wr only. Check the bus one-hot assertion over a 1000-cycle random program.
//  run dropped during EX1 of ADD -> EX2 completes, then IDLE with all controls 0.
//  ir=16'hF000 -> HALT, halted=1, run toggling ignored; rst_n=0 mid-EX2 -> immediate IDLE, flags_q=0.

Source files
------------

// File: rtl/sap_control_unit.sv
// sap_control_unit -- microcoded control sequencer for the 16-bit SAP datapath.
//
// Steps every instruction through IDLE -> F0 -> F1 -> DEC [-> EX1 -> EX2] and
// emits one control word per clock as a combinational decode of the current
// state, the opcode in ir[15:12] and the latched flags. The ALU zero/overflow
// flags are captured into flags_q only by ALU instructions; JZ/JO test flags_q.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   run             1 = execute, 0 = stop at the next instruction boundary
//   ir[15:0]        instruction register: [15:12] opcode, [11:0] operand
//   alu_flag[1:0]   live ALU flags: [0] zero, [1] overflow
//   pc_out_en, pc_inc, pc_load             program counter controls
//   mar_load, ram_rd, ram_wr               memory address/data controls
//   ir_load, ir_out_en                     instruction register controls
//   a_load, a_out_en, b_load, alu_out_en   accumulator / B / ALU controls
//   alu_op[3:0]     ALU operation, held for DEC..EX2 of ALU instructions
//   flags_q[1:0]    latched flags: [0] Z, [1] V
//   halted          1 while in HALT (left only through rst_n)

`ifndef ADD_OP
`define ADD_OP 4'd1
`define SUB_OP 4'd2
`define INC_OP 4'd3
`define DEC_OP 4'd4
`define AND_OP 4'd5
`define OR_OP  4'd6
`define XOR_OP 4'd7
`define NOT_OP 4'd8
`endif

module sap_control_unit #(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [15:0]        ir,
  input  logic [1:0]         alu_flag,
  output logic               pc_out_en,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               mar_load,
  output logic               ram_rd,
  output logic               ram_wr,
  output logic               ir_load,
  output logic               ir_out_en,
  output logic               a_load,
  output logic               a_out_en,
  output logic               b_load,
  output logic               alu_out_en,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         flags_q,
  output logic               halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_DEC, S_EX1, S_EX2, S_HALT
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOP = 'h0, OP_LDA = 'h1, OP_ADD = 'h2,
                               OP_SUB = 'h3, OP_STA = 'h4, OP_LDI = 'h5,
                               OP_JMP = 'h6, OP_JZ  = 'h7, OP_JO  = 'h8,
                               OP_INC = 'h9, OP_DEC = 'hA, OP_AND = 'hB,
                               OP_OR  = 'hC, OP_XOR = 'hD, OP_NOT = 'hE,
                               OP_HLT = 'hF;

  state_t           state, state_nxt;
  logic             flag_load;
  logic [OPC_W-1:0] opc;

  // The operand field is consumed by the datapath, not by the sequencer.
  logic unused_operand;
  assign unused_operand = ^ir[15-OPC_W:0];

  assign opc = ir[15 -: OPC_W];

  // ALU code for an opcode; 0 for everything that does not use the ALU.
  function automatic logic [ALUOP_W-1:0] alu_code(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD:  alu_code = ALUOP_W'(`ADD_OP);
      OP_SUB:  alu_code = ALUOP_W'(`SUB_OP);
      OP_INC:  alu_code = ALUOP_W'(`INC_OP);
      OP_DEC:  alu_code = ALUOP_W'(`DEC_OP);
      OP_AND:  alu_code = ALUOP_W'(`AND_OP);
      OP_OR:   alu_code = ALUOP_W'(`OR_OP);
      OP_XOR:  alu_code = ALUOP_W'(`XOR_OP);
      OP_NOT:  alu_code = ALUOP_W'(`NOT_OP);
      default: alu_code = '0;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      flags_q <= 2'b00;
    end else begin
      state <= state_nxt;
      if (flag_load) flags_q <= alu_flag;
    end
  end

  // NOTE: every output of this block is given a default before the case so
  // that no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    flag_load  = 1'b0;
    pc_out_en  = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    ir_load    = 1'b0;
    ir_out_en  = 1'b0;
    a_load     = 1'b0;
    a_out_en   = 1'b0;
    b_load     = 1'b0;
    alu_out_en = 1'b0;
    alu_op     = '0;
    halted     = 1'b0;

    case (state)
      S_IDLE: if (run) state_nxt = S_F0;

      S_F0: begin
        pc_out_en = 1'b1;
        mar_load  = 1'b1;
        state_nxt = S_F1;
      end

      S_F1: begin
        ram_rd    = 1'b1;
        ir_load   = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_DEC;
      end

      S_DEC: begin
        alu_op    = alu_code(opc);
        state_nxt = run ? S_F0 : S_IDLE;  // instruction boundary by default
        case (opc)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STA: begin
            ir_out_en = 1'b1;
            mar_load  = 1'b1;
            state_nxt = S_EX1;
          end
          OP_LDI: begin
            ir_out_en = 1'b1;
            a_load    = 1'b1;
          end
          OP_JMP: begin
            ir_out_en = 1'b1;
            pc_load   = 1'b1;
          end
          OP_JZ, OP_JO: begin
            // Taken only on the latched flag, never the live ALU output.
            if ((opc == OP_JZ) ? flags_q[0] : flags_q[1]) begin
              ir_out_en = 1'b1;
              pc_load   = 1'b1;
            end
          end
          OP_INC, OP_DEC, OP_NOT: begin
            alu_out_en = 1'b1;
            a_load     = 1'b1;
            flag_load  = 1'b1;
          end
          OP_HLT:  state_nxt = S_HALT;
          default: ;  // NOP
        endcase
      end

      S_EX1: begin
        alu_op = alu_code(opc);
        case (opc)
          OP_LDA: begin
            ram_rd    = 1'b1;
            a_load    = 1'b1;
            state_nxt = run ? S_F0 : S_IDLE;
          end
          OP_STA: begin
            a_out_en  = 1'b1;
            ram_wr    = 1'b1;
            state_nxt = run ? S_F0 : S_IDLE;
          end
          default: begin
            ram_rd    = 1'b1;
            b_load    = 1'b1;
            state_nxt = S_EX2;
          end
        endcase
      end

      S_EX2: begin
        alu_op     = alu_code(opc);
        alu_out_en = 1'b1;
        a_load     = 1'b1;
        flag_load  = 1'b1;
        state_nxt  = run ? S_F0 : S_IDLE;
      end

      S_HALT: halted = 1'b1;

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sap_control_unit.sv
// Self-checking bench for sap_control_unit. A behavioural model builds the
// per-cycle control words of each instruction from its opcode once the
// instruction is fetched, and a compare process checks the DUT against the
// model on every falling edge. Directed sequences pin the model with
// hand-computed expectations; a random program covers the rest.

`ifndef ADD_OP
`define ADD_OP 4'd1
`define SUB_OP 4'd2
`define INC_OP 4'd3
`define DEC_OP 4'd4
`define AND_OP 4'd5
`define OR_OP  4'd6
`define XOR_OP 4'd7
`define NOT_OP 4'd8
`endif

module tb_sap_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic [1:0]  alu_flag = 2'b00;
  logic        pc_out_en, pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load;
  logic        ir_out_en, a_load, a_out_en, b_load, alu_out_en, halted;
  logic [3:0]  alu_op;
  logic [1:0]  flags_q;

  sap_control_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir(ir), .alu_flag(alu_flag),
    .pc_out_en(pc_out_en), .pc_inc(pc_inc), .pc_load(pc_load),
    .mar_load(mar_load), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ir_load(ir_load), .ir_out_en(ir_out_en), .a_load(a_load),
    .a_out_en(a_out_en), .b_load(b_load), .alu_out_en(alu_out_en),
    .alu_op(alu_op), .flags_q(flags_q), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       flag_load;  // model-only: flags are captured at this cycle's end
    logic       halted;
    logic       pc_out_en, pc_inc, pc_load, mar_load, ram_rd, ram_wr;
    logic       ir_load, ir_out_en, a_load, a_out_en, b_load, alu_out_en;
    logic [3:0] alu_op;
  } word_t;

  typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;

  int          nchk = 0;
  int          nerr = 0;
  bit          chk_en = 1'b0;
  mode_t       mode;
  word_t       q[$];
  logic [1:0]  mflags;
  int          midx;
  bit          halt_pend;
  logic [15:0] nxt_ir = 16'h0000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic word_t dut_word();
    word_t w;
    w = '{flag_load: 1'b0, halted: halted, pc_out_en: pc_out_en, pc_inc: pc_inc,
          pc_load: pc_load, mar_load: mar_load, ram_rd: ram_rd, ram_wr: ram_wr,
          ir_load: ir_load, ir_out_en: ir_out_en, a_load: a_load,
          a_out_en: a_out_en, b_load: b_load, alu_out_en: alu_out_en,
          alu_op: alu_op};
    return w;
  endfunction

  function automatic logic [3:0] alu_of(input logic [3:0] op);
    case (op)
      4'h2: return `ADD_OP;
      4'h3: return `SUB_OP;
      4'h9: return `INC_OP;
      4'hA: return `DEC_OP;
      4'hB: return `AND_OP;
      4'hC: return `OR_OP;
      4'hD: return `XOR_OP;
      4'hE: return `NOT_OP;
      default: return 4'd0;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  task automatic load_fetch();
    word_t w;
    w = '0; w.pc_out_en = 1'b1; w.mar_load = 1'b1; q.push_back(w);
    w = '0; w.ram_rd = 1'b1; w.ir_load = 1'b1; w.pc_inc = 1'b1; q.push_back(w);
    midx = 0;
  endtask

  // Appends the decode/execute cycles of one instruction.
  task automatic build_exec(input logic [3:0] op);
    word_t w;
    bit    alu_class;
    alu_class = (op inside {4'h2, 4'h3, 4'hB, 4'hC, 4'hD});
    w = '0;
    w.alu_op = alu_of(op);
    if (alu_class || op == 4'h1 || op == 4'h4) begin
      w.ir_out_en = 1'b1; w.mar_load = 1'b1; q.push_back(w);
      w = '0;
      w.alu_op = alu_of(op);
      if (op == 4'h1) begin w.ram_rd = 1'b1; w.a_load = 1'b1; end
      else if (op == 4'h4) begin w.a_out_en = 1'b1; w.ram_wr = 1'b1; end
      else begin w.ram_rd = 1'b1; w.b_load = 1'b1; end
      q.push_back(w);
      if (alu_class) begin
        w = '0;
        w.alu_op = alu_of(op);
        w.alu_out_en = 1'b1; w.a_load = 1'b1; w.flag_load = 1'b1;
        q.push_back(w);
      end
    end else begin
      case (op)
        4'h5: begin w.ir_out_en = 1'b1; w.a_load = 1'b1; end
        4'h6: begin w.ir_out_en = 1'b1; w.pc_load = 1'b1; end
        4'h7: if (mflags[0]) begin w.ir_out_en = 1'b1; w.pc_load = 1'b1; end
        4'h8: if (mflags[1]) begin w.ir_out_en = 1'b1; w.pc_load = 1'b1; end
        4'h9, 4'hA, 4'hE: begin w.alu_out_en = 1'b1; w.a_load = 1'b1; w.flag_load = 1'b1; end
        4'hF: halt_pend = 1'b1;
        default: ;
      endcase
      q.push_back(w);
    end
  endtask

  task automatic model_reset();
    mode = M_IDLE; q.delete(); mflags = 2'b00; midx = 0; halt_pend = 1'b0;
  endtask

  // Advances the model across one rising edge with the inputs that edge saw.
  task automatic model_adv(input logic r, input logic [1:0] af);
    word_t w;
    case (mode)
      M_IDLE: if (r) begin mode = M_RUN; load_fetch(); end
      M_RUN: begin
        w = q.pop_front();
        midx++;
        if (w.flag_load) mflags = af;
        if (w.ir_load) begin
          ir = nxt_ir;
          build_exec(nxt_ir[15:12]);
        end
        if (q.size() == 0) begin
          if (halt_pend) begin mode = M_HALT; halt_pend = 1'b0; end
          else if (r) load_fetch();
          else mode = M_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  function automatic word_t model_word();
    word_t w;
    w = '0;
    if (mode == M_HALT) w.halted = 1'b1;
    else if (mode == M_RUN) w = q[0];
    w.flag_load = 1'b0;
    return w;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int drivers;
      check("ctl_word", 32'(dut_word()), 32'(model_word()));
      check("flags_q", 32'(flags_q), 32'(mflags));
      drivers = int'(pc_out_en) + int'(ram_rd) + int'(ir_out_en) + int'(a_out_en) + int'(alu_out_en);
      check("bus_onehot", 32'(drivers <= 1 && !(ram_rd && ram_wr)), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  // One clock: drive inputs, pass the edge, update the model, settle after the
  // following falling edge (where the compare process has already run).
  task automatic cyc(input logic r, input logic [1:0] af);
    run = r;
    alu_flag = af;
    @(posedge clk);
    #1;
    model_adv(r, af);
    @(negedge clk);
    #1;
  endtask

  // Runs one instruction starting from F0, recording the DUT word each cycle.
  // run drops to 0 from cycle index drop_at onward.
  task automatic exec(input logic [15:0] instr, input int drop_at, input logic [1:0] af,
                      output int n, output word_t obs[8]);
    nxt_ir = instr;
    n = 0;
    do begin
      obs[n] = dut_word();
      cyc((n < drop_at) ? 1'b1 : 1'b0, af);
      n++;
    end while (mode == M_RUN && midx != 0 && n < 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    word_t obs[8];
    word_t sta_w;
    int    n, cnt;

    model_reset();
    #2;
    check("reset_ctl", 32'(dut_word()), 32'd0);
    check("reset_flags", 32'(flags_q), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // NOP stream: three-cycle instructions, one pc_inc pulse each.
    nxt_ir = 16'h0000;
    cyc(1'b1, 2'b00);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cnt += int'(pc_inc);
      if (i < 8) cyc(1'b1, 2'b00);
    end
    check("nop_pc_inc_count", 32'(cnt), 32'd3);
    cyc(1'b1, 2'b00);

    // ADD: five cycles, alu_op held DEC..EX2, flags captured at EX2.
    exec(16'h2034, 99, 2'b01, n, obs);
    check("add_len", 32'(n), 32'd5);
    check("add_aluop_dec", 32'(obs[2].alu_op), 32'(`ADD_OP));
    check("add_aluop_ex2", 32'(obs[4].alu_op), 32'(`ADD_OP));
    check("add_f1_aluop", 32'(obs[1].alu_op), 32'd0);
    check("add_flags", 32'(flags_q), 32'h1);

    // JZ with Z=1 is taken.
    exec(16'h7100, 99, 2'b10, n, obs);
    check("jz_taken_len", 32'(n), 32'd3);
    check("jz_taken_pcload", 32'({obs[2].pc_load, obs[2].ir_out_en}), 32'h3);
    check("jz_keeps_flags", 32'(flags_q), 32'h1);

    // INC clears the flags, then JZ is not taken.
    exec(16'h9000, 99, 2'b00, n, obs);
    check("inc_flags", 32'(flags_q), 32'h0);
    exec(16'h7100, 99, 2'b11, n, obs);
    check("jz_not_taken", 32'({obs[2].pc_load, obs[2].ir_out_en}), 32'h0);

    // STA: EX1 drives only a_out_en and ram_wr.
    exec(16'h4010, 99, 2'b11, n, obs);
    sta_w = '0; sta_w.a_out_en = 1'b1; sta_w.ram_wr = 1'b1;
    check("sta_len", 32'(n), 32'd4);
    check("sta_ex1", 32'(obs[3]), 32'(sta_w));

    // Random program (no HLT), run occasionally dropped.
    for (int i = 0; i < 1000; i++) begin
      nxt_ir = {4'($urandom_range(0, 14)), 12'($urandom)};
      cyc(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0, 2'($urandom));
    end
    begin
      int k;
      k = 0;
      nxt_ir = 16'h0000;
      while (!(mode == M_RUN && midx == 0) && k < 20) begin
        cyc(1'b1, 2'b00);
        k++;
      end
      check("resync_bound", 32'(k < 20), 32'd1);
    end

    // run dropped during EX1 of ADD: completes, then IDLE with controls 0.
    exec(16'h2034, 3, 2'b10, n, obs);
    check("drop_len", 32'(n), 32'd5);
    check("drop_idle_ctl", 32'(dut_word()), 32'd0);
    check("drop_flags", 32'(flags_q), 32'h2);
    cyc(1'b0, 2'b00);
    check("idle_stays", 32'(dut_word()), 32'd0);
    cyc(1'b1, 2'b00);

    // HLT: halted held, run ignored.
    exec(16'hF000, 99, 2'b00, n, obs);
    check("hlt_len", 32'(n), 32'd3);
    for (int i = 0; i < 6; i++) begin
      cyc(1'(i), 2'($urandom));
      check("halt_held", 32'({halted, pc_out_en, mar_load}), 32'h4);
    end

    // Reset out of HALT, set flags, then reset in the middle of EX2.
    rst_n = 1'b0;
    #1;
    model_reset();
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 2'b00);
    exec(16'h9000, 99, 2'b11, n, obs);
    check("inc_flags_11", 32'(flags_q), 32'h3);
    nxt_ir = 16'h2034;
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00);
    check("in_ex2", 32'({alu_out_en, b_load}), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("abort_ctl", 32'(dut_word()), 32'd0);
    check("abort_flags", 32'(flags_q), 32'd0);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 2'b00);
    cyc(1'b0, 2'b00);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
